// File: rtl/modexp_ladder_engine.sv
// modexp_ladder_engine
// Montgomery-ladder modular exponentiation: result = x^e mod n over the low
// ebits bits of e (ebits clamped to EW). Products use an in-house Blakley
// bit-serial interleaved modular multiplier (one bit per cycle, W cycles per
// product), so the latency depends only on W and ebits, never on the values.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         request, sampled only while idle
//   abort         synchronous cancel of a running operation
//   x, e, n       base, exponent, modulus (latched when start is accepted)
//   ebits         number of exponent LSBs processed
//   busy          high from accepted start until done or abort
//   done          one-cycle pulse; result/err valid
//   err           set with done when n < 2
//   result        x^e mod n, held until the next accepted start
module modexp_ladder_engine #(
  parameter int W  = 256,
  parameter int EW = 256,
  parameter int CW = $clog2(EW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  x,
  input  logic [EW-1:0] e,
  input  logic [W-1:0]  n,
  input  logic [CW-1:0] ebits,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result
);

  localparam int JW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_REDUCE   = 3'd2;
  localparam logic [2:0] ST_DISPATCH = 3'd3;
  localparam logic [2:0] ST_MULA     = 3'd4;
  localparam logic [2:0] ST_MULB     = 3'd5;
  localparam logic [2:0] ST_FINISH   = 3'd6;

  localparam logic [JW-1:0] J_LAST    = JW'(W - 1);
  localparam logic [JW-1:0] J_ZERO    = JW'(0);
  localparam logic [CW-1:0] EBITS_MAX = CW'(EW);
  localparam logic [CW-1:0] CW_ONE    = CW'(1);
  localparam logic [CW-1:0] CW_ZERO   = CW'(0);
  localparam logic [W-1:0]  W_ONE     = W'(1);
  localparam logic [W-1:0]  W_TWO     = W'(2);
  localparam logic [EW-1:0] EW_ONE    = EW'(1);

  logic [2:0]    state_r;
  logic [W-1:0]  x_r;
  logic [EW-1:0] e_r;
  logic [W-1:0]  n_r;
  logic [CW-1:0] rem_r;   // exponent bits still to process; current bit is rem_r-1
  logic [JW-1:0] cnt_r;   // multiplier bit index j, counts W-1 down to 0
  logic [W-1:0]  p_r;     // multiplier accumulator
  logic [W-1:0]  r0_r;
  logic [W-1:0]  r1_r;

  logic [CW-1:0] bit_idx_s;
  logic          e_bit_s;
  logic [W-1:0]  a_s;
  logic [W-1:0]  b_s;
  logic          b_bit_s;
  logic [W:0]    n_ext_s;
  logic [W:0]    t_dbl_s;
  logic [W:0]    t_red_s;
  logic [W:0]    t_add_s;
  logic [W-1:0]  p_next_s;

  assign bit_idx_s = rem_r - CW_ONE;
  assign n_ext_s   = {1'b0, n_r};

  // Current exponent bit; a mask avoids an oversized bit-select index.
  always_comb begin
    e_bit_s = |(e_r & (EW_ONE << bit_idx_s));
  end

  // Multiplier operand selection. MULA always forms R0*R1 (only the
  // destination depends on the bit); MULB squares the register MULA left alone.
  always_comb begin
    a_s = '0;
    b_s = '0;
    case (state_r)
      ST_REDUCE: begin
        a_s = W_ONE;
        b_s = x_r;
      end
      ST_MULA: begin
        a_s = r0_r;
        b_s = r1_r;
      end
      ST_MULB: begin
        a_s = e_bit_s ? r1_r : r0_r;
        b_s = e_bit_s ? r1_r : r0_r;
      end
      default: begin
        a_s = '0;
        b_s = '0;
      end
    endcase
    b_bit_s = b_s[cnt_r];
  end

  // One Blakley step: P' = ((2P mod n) + b[j]*a) mod n with W+1-bit adders.
  always_comb begin
    t_dbl_s = {p_r, 1'b0};
    if (t_dbl_s >= n_ext_s) begin
      t_red_s = t_dbl_s - n_ext_s;
    end else begin
      t_red_s = t_dbl_s;
    end
    if (b_bit_s) begin
      t_add_s = t_red_s + {1'b0, a_s};
    end else begin
      t_add_s = t_red_s;
    end
    if (t_add_s >= n_ext_s) begin
      p_next_s = W'(t_add_s - n_ext_s);
    end else begin
      p_next_s = W'(t_add_s);
    end
  end

  // Control FSM, operand latches, ladder registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      x_r     <= '0;
      e_r     <= '0;
      n_r     <= '0;
      rem_r   <= '0;
      cnt_r   <= '0;
      p_r     <= '0;
      r0_r    <= '0;
      r1_r    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      // FINISH is excluded: the operation is already complete, so done wins.
      if (abort && (state_r != ST_IDLE) && (state_r != ST_FINISH)) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              x_r     <= x;
              e_r     <= e;
              n_r     <= n;
              rem_r   <= (ebits > EBITS_MAX) ? EBITS_MAX : ebits;
              busy    <= 1'b1;
              err     <= 1'b0;
              result  <= '0;
              state_r <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (n_r < W_TWO) begin
              err     <= 1'b1;
              state_r <= ST_FINISH;
            end else begin
              r0_r    <= W_ONE;
              p_r     <= '0;
              cnt_r   <= J_LAST;
              state_r <= ST_REDUCE;
            end
          end
          ST_REDUCE: begin
            p_r <= p_next_s;
            if (cnt_r == J_ZERO) begin
              r1_r    <= p_next_s;
              state_r <= ST_DISPATCH;
            end else begin
              cnt_r <= cnt_r - JW'(1);
            end
          end
          ST_DISPATCH: begin
            if (rem_r == CW_ZERO) begin
              state_r <= ST_FINISH;
            end else begin
              p_r     <= '0;
              cnt_r   <= J_LAST;
              state_r <= ST_MULA;
            end
          end
          ST_MULA: begin
            if (cnt_r == J_ZERO) begin
              if (e_bit_s) begin
                r0_r <= p_next_s;
              end else begin
                r1_r <= p_next_s;
              end
              p_r     <= '0;
              cnt_r   <= J_LAST;
              state_r <= ST_MULB;
            end else begin
              p_r   <= p_next_s;
              cnt_r <= cnt_r - JW'(1);
            end
          end
          ST_MULB: begin
            if (cnt_r == J_ZERO) begin
              if (e_bit_s) begin
                r1_r <= p_next_s;
              end else begin
                r0_r <= p_next_s;
              end
              p_r     <= '0;
              rem_r   <= rem_r - CW_ONE;
              state_r <= ST_DISPATCH;
            end else begin
              p_r   <= p_next_s;
              cnt_r <= cnt_r - JW'(1);
            end
          end
          ST_FINISH: begin
            result  <= err ? '0 : r0_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modexp_ladder_engine.sv
// tb_modexp_ladder_engine
// Self-checking bench for modexp_ladder_engine at W=16, EW=16. Each operation
// pushes its expected outcome (result, err, latency, aborted) into a queue;
// the entry is popped and compared when the engine reports done or drops busy.
module tb_modexp_ladder_engine;

  localparam int W  = 16;
  localparam int EW = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  x = '0;
  logic [EW-1:0] e = '0;
  logic [W-1:0]  n = '0;
  logic [CW-1:0] ebits = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;

  typedef struct {
    longint res;
    longint err;
    int     lat;
    bit     aborted;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  modexp_ladder_engine #(.W(W), .EW(EW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x(x), .e(e), .n(n), .ebits(ebits),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Plain left-to-right square-and-multiply reference.
  function automatic longint ref_modexp(longint xv, longint ev, longint nv, int eb);
    longint r, b;
    if (nv < 2) return 0;
    r = 1;
    b = xv % nv;
    for (int i = eb - 1; i >= 0; i--) begin
      r = (r * r) % nv;
      if (ev[i]) r = (r * b) % nv;
    end
    return r;
  endfunction

  // Runs one operation from a point #1 after a rising edge.
  // abort_cyc: abort is high in the cycle sampled by edge abort_cyc (<=0: never).
  task automatic run_op(input logic [15:0] xi, input logic [15:0] ei,
                        input logic [15:0] ni, input logic [4:0] ebi,
                        input int abort_cyc, input bit perturb, input bit abort_with_start);
    exp_t ex, got_ex;
    int   eb_cl, k, quiet;
    bit   seen, ended;
    eb_cl = (ebi > 5'd16) ? 16 : int'(ebi);
    ex.lat = (ni < 16'd2) ? 2 : (W + eb_cl * (2 * W + 1) + 3);
    ex.aborted = (abort_cyc > 0) && (abort_cyc < ex.lat);
    if (ex.aborted) begin
      ex.lat = abort_cyc;
      ex.res = 0;
      ex.err = 0;
    end else begin
      ex.res = ref_modexp(longint'(xi), longint'(ei), longint'(ni), eb_cl);
      ex.err = (ni < 16'd2) ? 1 : 0;
    end
    sb_q.push_back(ex);

    x = xi; e = ei; n = ni; ebits = ebi;
    start = 1'b1;
    abort = abort_with_start;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    if (perturb) begin
      x = 16'h1234; e = 16'h0000; n = 16'd3; ebits = 5'd1;
    end

    k = 0; seen = 1'b0; ended = 1'b0;
    while (!ended && k < 2000) begin
      abort = (k + 1 == abort_cyc);
      start = perturb && (k == 10);
      @(posedge clk); #1;
      k++;
      if (done) begin
        seen = 1'b1;
        ended = 1'b1;
      end else if (!busy) begin
        ended = 1'b1;
      end
    end
    abort = 1'b0;
    start = 1'b0;

    got_ex = sb_q.pop_front();
    check("done_seen", longint'(seen), got_ex.aborted ? 0 : 1);
    check("latency", longint'(k), longint'(got_ex.lat));
    check("result", longint'(result), got_ex.res);
    check("err", longint'(err), got_ex.err);
    check("busy_after", longint'(busy), 0);
    if (seen) begin
      @(posedge clk); #1;
      check("done_pulse", longint'(done), 0);
    end else begin
      quiet = 0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (done || busy) quiet++;
      end
      check("no_late_done", longint'(quiet), 0);
    end
  endtask

  initial begin
    #12;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    check("rst_result", longint'(result), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic ladder, input reduction, ebits = 0.
    run_op(16'd4, 16'd13, 16'd497, 5'd4, -1, 1'b0, 1'b0);
    run_op(16'd1000, 16'd1, 16'd497, 5'd1, -1, 1'b0, 1'b0);
    run_op(16'd5, 16'hFFFF, 16'hFFF1, 5'd0, -1, 1'b0, 1'b0);

    // Degenerate moduli, then a valid operation clears err.
    run_op(16'd9, 16'd5, 16'd1, 5'd3, -1, 1'b0, 1'b0);
    run_op(16'd9, 16'd5, 16'd0, 5'd3, -1, 1'b0, 1'b0);
    run_op(16'd4, 16'd13, 16'd497, 5'd4, -1, 1'b0, 1'b0);

    // Constant-time: all-zero and all-one exponents; ebits above EW clamps.
    run_op(16'd7, 16'h0000, 16'hFFFB, 5'd16, -1, 1'b0, 1'b0);
    run_op(16'd7, 16'hFFFF, 16'hFFFB, 5'd16, -1, 1'b0, 1'b0);
    run_op(16'd7, 16'hFFFF, 16'hFFFB, 5'd31, -1, 1'b0, 1'b0);

    // Restart and input changes while busy are ignored.
    run_op(16'd4, 16'd13, 16'd497, 5'd4, -1, 1'b1, 1'b0);

    // Abort mid-run; abort during FINISH loses to done; start+abort in idle.
    run_op(16'd4, 16'd13, 16'd497, 5'd4, 40, 1'b0, 1'b0);
    run_op(16'd4, 16'd13, 16'd497, 5'd4, 151, 1'b0, 1'b0);
    run_op(16'd4, 16'd13, 16'd497, 5'd4, -1, 1'b0, 1'b1);

    // Abort alone in idle does nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_busy", longint'(busy), 0);
    check("idle_abort_done", longint'(done), 0);
    check("idle_abort_result", longint'(result), 445);

    // Asynchronous reset in the middle of an operation.
    x = 16'd4; e = 16'd13; n = 16'd497; ebits = 5'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #4;
    check("pre_rst_busy", longint'(busy), 1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", longint'(busy), 0);
    check("async_rst_done", longint'(done), 0);
    check("async_rst_err", longint'(err), 0);
    check("async_rst_result", longint'(result), 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", longint'(busy), 0);
    run_op(16'd4, 16'd13, 16'd497, 5'd4, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
